// File: rtl/pipe_stage_chain.sv
// Parametrised stage-register chain with per-stage stall/flush, valid tracking
// and saturating retire / stall-cycle performance counters.
module pipe_stage_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    input  logic                   clear_counters,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       retire_count,
    output logic [CNT_W-1:0]       stall_cycles
);

    logic [DEPTH-1:0] hold;
    logic             valid_q [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic             retire;

    // A stall anywhere downstream freezes every stage up to and including it.
    always_comb begin
        hold = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hold[k] = |(stall >> k);
        end
    end

    assign in_ready = ~hold[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic             bubble;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_valid ? in_data : '0;
            assign bubble     = 1'b0;
        end else begin : g_body
            assign prev_valid = valid_q[k-1];
            assign prev_data  = data_q[k-1];
            assign bubble     = hold[k-1];
        end

        // Priority: flush, hold, bubble, advance.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end else if (flush[k]) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end else if (!hold[k]) begin
                if (bubble) begin
                    valid_q[k] <= 1'b0;
                    data_q[k]  <= '0;
                end else begin
                    valid_q[k] <= prev_valid;
                    data_q[k]  <= prev_data;
                end
            end
        end

        assign stage_valid[k]              = valid_q[k];
        assign stage_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // A flushed last stage is discarded, not retired.
    assign retire = valid_q[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
            stall_cycles <= '0;
        end else if (clear_counters) begin
            retire_count <= '0;
            stall_cycles <= '0;
        end else begin
            if (retire && (retire_count != '1)) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            if (hold[0] && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=4, CNT_W=4).
module tb_pipe_stage_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic                   clear_counters;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       retire_count;
    logic [CNT_W-1:0]       stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .stall          (stall),
        .flush          (flush),
        .clear_counters (clear_counters),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .retire_count   (retire_count),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic               in_valid;
        logic [WIDTH-1:0]   in_data;
        logic [DEPTH-1:0]   exp_valid;
        logic [4*WIDTH-1:0] exp_data;
        logic               exp_out_valid;
        logic [WIDTH-1:0]   exp_out_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Active edge then 1 time unit of settle; inputs change here too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h11, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h11}, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h22, 4'b0011, {32'h0, 32'h0, 32'h11, 32'h22}, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h33, 4'b0111, {32'h0, 32'h11, 32'h22, 32'h33}, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h00, 4'b1110, {32'h11, 32'h22, 32'h33, 32'h0}, 1'b1, 32'h11};
        vecs[4] = '{1'b0, 32'h00, 4'b1100, {32'h22, 32'h33, 32'h0, 32'h0}, 1'b1, 32'h22};
        vecs[5] = '{1'b0, 32'h00, 4'b1000, {32'h33, 32'h0, 32'h0, 32'h0}, 1'b1, 32'h33};
        vecs[6] = '{1'b0, 32'h00, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 32'h0};

        reset = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        stall = '0; flush = '0; clear_counters = 1'b0;
        tick(); tick();
        chk("rst_valid", 128'(stage_valid), 128'h0);
        chk("rst_data", 128'(stage_data), 128'h0);
        chk("rst_out", 128'({out_valid, out_data}), 128'h0);
        chk("rst_cnt", 128'({retire_count, stall_cycles}), 128'h0);
        chk("rst_ready", 128'(in_ready), 128'h1);
        reset = 1'b1;

        // Streaming table: inputs before the edge, state after it.
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            #1;
            chk($sformatf("stream%0d_ready", i), 128'(in_ready), 128'h1);
            tick();
            chk($sformatf("stream%0d_valid", i), 128'(stage_valid), 128'(vecs[i].exp_valid));
            chk($sformatf("stream%0d_data", i), 128'(stage_data), 128'(vecs[i].exp_data));
            chk($sformatf("stream%0d_out", i), 128'({out_valid, out_data}),
                128'({vecs[i].exp_out_valid, vecs[i].exp_out_data}));
        end
        chk("stream_retire", 128'(retire_count), 128'h3);
        chk("stream_stalls", 128'(stall_cycles), 128'h0);

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; in_data = 32'h44; tick();
        in_data = 32'h45; tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 128'(stage_valid), 128'h0);
        chk("midrst_data", 128'(stage_data), 128'h0);
        chk("midrst_retire", 128'(retire_count), 128'h0);
        chk("midrst_ready", 128'(in_ready), 128'h1);
        tick();
        reset = 1'b1;
        in_valid = 1'b1; in_data = 32'h77; tick();
        in_valid = 1'b0; tick(); tick();
        chk("post_rst_early", 128'(out_valid), 128'h0);
        tick();
        chk("post_rst_latency", 128'({out_valid, out_data}), 128'({1'b1, 32'h77}));

        // Fill with D,C,B,A; clearing on the edge that would retire 0x77.
        clear_counters = 1'b1; in_valid = 1'b1; in_data = 32'hDD; tick();
        clear_counters = 1'b0;
        in_data = 32'hCC; tick();
        in_data = 32'hBB; tick();
        in_data = 32'hAA; tick();
        chk("fill_data", 128'(stage_data), {32'hDD, 32'hCC, 32'hBB, 32'hAA});
        chk("fill_cnt", 128'({retire_count, stall_cycles}), 128'h0);

        // Stall stage 1 for two cycles with E waiting.
        stall = 4'b0010; in_data = 32'hEE;
        #1;
        chk("stall_ready", 128'(in_ready), 128'h0);
        tick();
        chk("stall1_valid", 128'(stage_valid), 128'b1011);
        chk("stall1_data", 128'(stage_data), {32'hCC, 32'h0, 32'hBB, 32'hAA});
        chk("stall1_retire", 128'(retire_count), 128'h1);
        tick();
        chk("stall2_valid", 128'(stage_valid), 128'b0011);
        chk("stall2_data", 128'(stage_data), {32'h0, 32'h0, 32'hBB, 32'hAA});
        chk("stall2_cnt", 128'({retire_count, stall_cycles}), 128'({4'd2, 4'd2}));
        stall = '0;
        #1;
        chk("release_ready", 128'(in_ready), 128'h1);
        tick();
        chk("release_data", 128'(stage_data), {32'h0, 32'hBB, 32'hAA, 32'hEE});
        chk("release_valid", 128'(stage_valid), 128'b0111);

        // Simultaneous stall and flush.
        in_data = 32'hFF; tick();
        chk("full_data", 128'(stage_data), {32'hBB, 32'hAA, 32'hEE, 32'hFF});
        stall = 4'b0010; flush = 4'b0011; in_data = 32'h99;
        #1;
        chk("flushstall_ready", 128'(in_ready), 128'h0);
        tick();
        stall = '0; flush = '0; in_valid = 1'b0;
        chk("flushstall_valid", 128'(stage_valid), 128'b1000);
        chk("flushstall_data", 128'(stage_data), {32'hAA, 32'h0, 32'h0, 32'h0});
        chk("flushstall_cnt", 128'({retire_count, stall_cycles}), 128'({4'd3, 4'd3}));

        // Last-stage flush discards without retiring.
        flush = 4'b1000; tick();
        flush = '0;
        chk("lastflush_out", 128'({out_valid, out_data}), 128'h0);
        chk("lastflush_retire", 128'(retire_count), 128'h3);

        // Retire counter saturation.
        clear_counters = 1'b1; tick();
        clear_counters = 1'b0;
        chk("clear_cnt", 128'({retire_count, stall_cycles}), 128'h0);
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 20);
            in_data  = 32'(i + 1);
            tick();
            if (i == 17) chk("sat_retire14", 128'(retire_count), 128'd14);
            if (i == 18) chk("sat_retire15", 128'(retire_count), 128'd15);
        end
        chk("sat_retire_final", 128'(retire_count), 128'd15);

        // Stall-cycle saturation.
        in_valid = 1'b0; stall = 4'b0001;
        for (int i = 0; i < 16; i++) tick();
        stall = '0;
        chk("sat_stalls", 128'(stall_cycles), 128'd15);

        // Clear during a retire.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'(32'h100 + i);
            tick();
        end
        chk("preclr_out", 128'({out_valid, out_data}), 128'({1'b1, 32'h100}));
        clear_counters = 1'b1; tick();
        clear_counters = 1'b0;
        chk("clr_retire_cnt", 128'({retire_count, stall_cycles}), 128'h0);
        tick();
        chk("after_clr_retire", 128'(retire_count), 128'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
